// File: rtl/dig_ct_event_monitor.sv
// Rising-edge monitor with per-channel counters and ch0->ch1->ch2 sequence FSM.
// Optional DIG_CT_MON_SAT_EN: counters saturate and set sticky SAT flags.
module dig_ct_event_monitor #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [2:0]       SIG_IN,
  input  logic             CLR,
  input  logic [1:0]       CNT_SEL,
  output logic [CNT_W-1:0] CNT_OUT,
  output logic [2:0]       EDGE_OUT,
  output logic             MATCH,
  output logic [3:0]       SAT
);

  typedef enum logic [1:0] {
    IDLE,
    GOT0,
    GOT1
  } state_t;

  localparam logic [15:0] TMAX = 16'(TIMEOUT - 1);

  state_t           state;
  state_t           state_n;
  logic [15:0]      timer;
  logic [15:0]      timer_n;
  logic             match_n;
  logic [2:0]       s_q;
  logic             primed;
  logic [2:0]       e;
  logic [3:0]       inc;
  logic [CNT_W-1:0] cnt [4];

  assign e   = SIG_IN & ~s_q & {3{primed}};
  assign inc = {match_n, e};

  // previous-sample register and registered edge/match pulses
  always_ff @(posedge CLK) begin
    if (RST) begin
      s_q      <= '0;
      primed   <= 1'b0;
      EDGE_OUT <= '0;
      MATCH    <= 1'b0;
    end else begin
      s_q      <= SIG_IN;
      primed   <= 1'b1;
      EDGE_OUT <= e;
      MATCH    <= match_n;
    end
  end

  // sequence state and idle timer
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      timer <= '0;
    end else begin
      state <= state_n;
      timer <= timer_n;
    end
  end

  // next state: only single-bit edge vectors can advance
  always_comb begin
    state_n = state;
    timer_n = '0;
    match_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (e == 3'b001) state_n = GOT0;
      end
      GOT0: begin
        if (e == 3'b000) begin
          if (timer == TMAX) state_n = IDLE;
          else timer_n = timer + 16'd1;
        end else if (e == 3'b001) begin
          state_n = GOT0;
        end else if (e == 3'b010) begin
          state_n = GOT1;
        end else begin
          state_n = IDLE;
        end
      end
      GOT1: begin
        if (e == 3'b000) begin
          if (timer == TMAX) state_n = IDLE;
          else timer_n = timer + 16'd1;
        end else if (e == 3'b001) begin
          state_n = GOT0;
        end else if (e == 3'b100) begin
          state_n = IDLE;
          match_n = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef DIG_CT_MON_SAT_EN
  logic [3:0] sat_q;
  assign SAT = sat_q;

  // saturating counters; clear wins over a same-cycle increment
  always_ff @(posedge CLK) begin
    if (RST || CLR) begin
      sat_q <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (inc[i]) begin
          if (cnt[i] == {CNT_W{1'b1}}) sat_q[i] <= 1'b1;
          else cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end
`else
  assign SAT = 4'b0000;

  // wrapping counters; clear wins over a same-cycle increment
  always_ff @(posedge CLK) begin
    if (RST || CLR) begin
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (inc[i]) cnt[i] <= cnt[i] + CNT_W'(1);
      end
    end
  end
`endif

  assign CNT_OUT = cnt[CNT_SEL];

endmodule

// File: tb/tb_dig_ct_event_monitor.sv
// Directed bench for dig_ct_event_monitor.
// A second instance with CNT_W=2 exercises counter overflow.
module tb_dig_ct_event_monitor;

  logic       CLK = 1'b0;
  logic       RST;
  logic [2:0] SIG_IN;
  logic       CLR;
  logic [1:0] CNT_SEL;
  logic [7:0] cnt_out;
  logic [2:0] edge_out;
  logic       match;
  logic [3:0] sat;
  logic [1:0] cnt_out2;
  logic [2:0] edge_out2;
  logic       match2;
  logic [3:0] sat2;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  dig_ct_event_monitor #(.CNT_W(8), .TIMEOUT(16)) u0 (
    .CLK(CLK), .RST(RST), .SIG_IN(SIG_IN), .CLR(CLR),
    .CNT_SEL(CNT_SEL), .CNT_OUT(cnt_out), .EDGE_OUT(edge_out),
    .MATCH(match), .SAT(sat)
  );

  dig_ct_event_monitor #(.CNT_W(2), .TIMEOUT(16)) u1 (
    .CLK(CLK), .RST(RST), .SIG_IN(SIG_IN), .CLR(CLR),
    .CNT_SEL(CNT_SEL), .CNT_OUT(cnt_out2), .EDGE_OUT(edge_out2),
    .MATCH(match2), .SAT(sat2)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    SIG_IN = 3'b000;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clr();
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
  endtask

  task automatic rd(input logic [1:0] s, output logic [7:0] v);
    CNT_SEL = s;
    #1;
    v = cnt_out;
  endtask

  task automatic pulse(input int ch, output logic m);
    SIG_IN = 3'(1 << ch);
    tick();
    m = match;
    SIG_IN = 3'b000;
    tick();
  endtask

  task automatic test_reset();
    logic [7:0] v;
    RST = 1'b1;
    SIG_IN = 3'b111;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (edge_out !== 3'b000) begin
      errors++;
      $display("FAIL rst_edge got %b exp 000", edge_out);
    end
    checks++;
    if (match !== 1'b0 || sat !== 4'b0000) begin
      errors++;
      $display("FAIL rst_match_sat got %b %b exp 0 0000", match, sat);
    end
    for (int s = 0; s < 4; s++) begin
      rd(2'(s), v);
      checks++;
      if (v !== 8'd0) begin
        errors++;
        $display("FAIL rst_cnt%0d got %0d exp 0", s, v);
      end
    end
    RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (edge_out !== 3'b000) begin
        errors++;
        $display("FAIL held_high_edge got %b exp 000", edge_out);
      end
    end
    for (int s = 0; s < 3; s++) begin
      rd(2'(s), v);
      checks++;
      if (v !== 8'd0) begin
        errors++;
        $display("FAIL held_high_cnt%0d got %0d exp 0", s, v);
      end
    end
  endtask

  task automatic test_single();
    logic [7:0] v;
    idle(1);
    SIG_IN = 3'b001;
    tick();
    checks++;
    if (edge_out !== 3'b001) begin
      errors++;
      $display("FAIL single_edge got %b exp 001", edge_out);
    end
    tick();
    checks++;
    if (edge_out !== 3'b000) begin
      errors++;
      $display("FAIL single_once got %b exp 000", edge_out);
    end
    tick();
    idle(1);
    rd(2'd0, v);
    checks++;
    if (v !== 8'd1) begin
      errors++;
      $display("FAIL single_cnt got %0d exp 1", v);
    end
  endtask

  task automatic test_sequence();
    logic [7:0] v;
    logic       m;
    idle(20);
    clr();
    pulse(0, m);
    pulse(1, m);
    pulse(2, m);
    checks++;
    if (m !== 1'b1) begin
      errors++;
      $display("FAIL seq_match got %b exp 1", m);
    end
    checks++;
    if (match !== 1'b0) begin
      errors++;
      $display("FAIL seq_match_pulse got %b exp 0", match);
    end
    rd(2'd3, v);
    checks++;
    if (v !== 8'd1) begin
      errors++;
      $display("FAIL seq_mcnt got %0d exp 1", v);
    end
    for (int s = 0; s < 3; s++) begin
      rd(2'(s), v);
      checks++;
      if (v !== 8'd1) begin
        errors++;
        $display("FAIL seq_cnt%0d got %0d exp 1", s, v);
      end
    end
    pulse(0, m);
    pulse(2, m);
    checks++;
    if (m !== 1'b0) begin
      errors++;
      $display("FAIL seq_skip1 got %b exp 0", m);
    end
    rd(2'd3, v);
    checks++;
    if (v !== 8'd1) begin
      errors++;
      $display("FAIL seq_skip1_mcnt got %0d exp 1", v);
    end
  endtask

  task automatic test_timeout();
    logic [7:0] v;
    logic       m;
    clr();
    pulse(0, m);
    idle(15);
    pulse(1, m);
    pulse(2, m);
    checks++;
    if (m !== 1'b0) begin
      errors++;
      $display("FAIL tmo16_match got %b exp 0", m);
    end
    rd(2'd3, v);
    checks++;
    if (v !== 8'd0) begin
      errors++;
      $display("FAIL tmo16_mcnt got %0d exp 0", v);
    end
    pulse(0, m);
    idle(14);
    pulse(1, m);
    pulse(2, m);
    checks++;
    if (m !== 1'b1) begin
      errors++;
      $display("FAIL tmo15_match got %b exp 1", m);
    end
    rd(2'd3, v);
    checks++;
    if (v !== 8'd1) begin
      errors++;
      $display("FAIL tmo15_mcnt got %0d exp 1", v);
    end
  endtask

  task automatic test_sat();
    logic [7:0] v;
    logic       m;
    logic [1:0] exp_c;
    logic [3:0] exp_s;
`ifdef DIG_CT_MON_SAT_EN
    exp_c = 2'd3;
    exp_s = 4'b0010;
`else
    exp_c = 2'd1;
    exp_s = 4'b0000;
`endif
    clr();
    for (int i = 0; i < 5; i++) pulse(1, m);
    rd(2'd1, v);
    checks++;
    if (v !== 8'd5) begin
      errors++;
      $display("FAIL sat_wide_cnt got %0d exp 5", v);
    end
    checks++;
    if (sat !== 4'b0000) begin
      errors++;
      $display("FAIL sat_wide_flag got %b exp 0000", sat);
    end
    checks++;
    if (cnt_out2 !== exp_c) begin
      errors++;
      $display("FAIL sat_cnt got %0d exp %0d", cnt_out2, exp_c);
    end
    checks++;
    if (sat2 !== exp_s) begin
      errors++;
      $display("FAIL sat_flag got %b exp %b", sat2, exp_s);
    end
    SIG_IN = 3'b010;
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    SIG_IN = 3'b000;
    checks++;
    if (edge_out !== 3'b010) begin
      errors++;
      $display("FAIL clr_edge got %b exp 010", edge_out);
    end
    checks++;
    if (cnt_out2 !== 2'd0 || sat2 !== 4'b0000) begin
      errors++;
      $display("FAIL clr_beats_inc got %0d %b exp 0 0000", cnt_out2, sat2);
    end
    checks++;
    if (cnt_out !== 8'd0) begin
      errors++;
      $display("FAIL clr_wide got %0d exp 0", cnt_out);
    end
    tick();
  endtask

  task automatic test_multi();
    logic [7:0] v;
    logic       m;
    idle(2);
    clr();
    pulse(0, m);
    SIG_IN = 3'b011;
    tick();
    checks++;
    if (edge_out !== 3'b011) begin
      errors++;
      $display("FAIL multi_edge got %b exp 011", edge_out);
    end
    idle(1);
    pulse(2, m);
    checks++;
    if (m !== 1'b0) begin
      errors++;
      $display("FAIL multi_abort got %b exp 0", m);
    end
    rd(2'd0, v);
    checks++;
    if (v !== 8'd2) begin
      errors++;
      $display("FAIL multi_cnt0 got %0d exp 2", v);
    end
    rd(2'd1, v);
    checks++;
    if (v !== 8'd1) begin
      errors++;
      $display("FAIL multi_cnt1 got %0d exp 1", v);
    end
    pulse(0, m);
    pulse(1, m);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    rd(2'd0, v);
    checks++;
    if (v !== 8'd0 || edge_out !== 3'b000) begin
      errors++;
      $display("FAIL midrst got %0d %b exp 0 000", v, edge_out);
    end
    idle(1);
    SIG_IN = 3'b100;
    tick();
    checks++;
    if (edge_out !== 3'b100 || match !== 1'b0) begin
      errors++;
      $display("FAIL midrst_ch2 got %b %b exp 100 0", edge_out, match);
    end
    idle(1);
  endtask

  task automatic test_back_to_back();
    logic [7:0] v;
    clr();
    SIG_IN = 3'b001;
    tick();
    SIG_IN = 3'b010;
    tick();
    SIG_IN = 3'b100;
    tick();
    checks++;
    if (match !== 1'b1 || edge_out !== 3'b100) begin
      errors++;
      $display("FAIL b2b_m1 got %b %b exp 1 100", match, edge_out);
    end
    SIG_IN = 3'b001;
    tick();
    checks++;
    if (match !== 1'b0) begin
      errors++;
      $display("FAIL b2b_pulse got %b exp 0", match);
    end
    SIG_IN = 3'b010;
    tick();
    SIG_IN = 3'b100;
    tick();
    checks++;
    if (match !== 1'b1) begin
      errors++;
      $display("FAIL b2b_m2 got %b exp 1", match);
    end
    idle(1);
    rd(2'd3, v);
    checks++;
    if (v !== 8'd2) begin
      errors++;
      $display("FAIL b2b_mcnt got %0d exp 2", v);
    end
    rd(2'd0, v);
    checks++;
    if (v !== 8'd2) begin
      errors++;
      $display("FAIL b2b_cnt0 got %0d exp 2", v);
    end
  endtask

  initial begin
    RST = 1'b1;
    SIG_IN = 3'b000;
    CLR = 1'b0;
    CNT_SEL = 2'd0;
    test_reset();
    test_single();
    test_sequence();
    test_timeout();
    test_sat();
    test_multi();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
